i2c_target_regs: RTL and testbench
==================================

# i2c_target_regs

Standards-style I2C target (responder) with an internal byte-wide register file, answering a bus initiator on real open-drain SCL/SDA. It oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit device address, and ACKs by pulling SDA low rather than through a side-band ack wire. It sits on the same two-wire bus as the existing initiator and gives fabric logic a write-event port for every register updated over I2C.

## Interface
- DEV_ADDR, 7'h50, 7-bit target address compared against the address byte.
- N_REGS, 16, register count; power of 2, 2..256; AW = log2(N_REGS).
- clk  input  1  system clock; must be ≥ 8× SCL frequency.
- rst  input  1  asynchronous, active-low reset.
- scl  input  1  bus clock; the block never drives it.
- sda  inout  1  open-drain; the block drives only 1'b0 or 1'bz.
- wr_valid  output  1  one-clk pulse per register written over I2C.
- wr_reg  output  AW  index written; valid when wr_valid=1.
- wr_data  output  8  byte written; valid when wr_valid=1.
- busy  output  1  high from address match until the next START/STOP.

## Operation
- Input path: scl/sda each pass a 2-FF synchronizer, plus one history FF for edge detection.
- SCL rise/fall: synchronized scl 0→1 / 1→0.
- START: synchronized sda 1→0 while scl=1. STOP: sda 0→1 while scl=1.
- Bits are MSB first; data is sampled on the SCL rise; the block changes SDA only on a detected SCL fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits in.
  - On the 8th bit: if [7:1]==DEV_ADDR, go to ADDR_ACK; otherwise go to IGNORE.
  - ADDR_ACK: pull SDA low from the next SCL fall to the following SCL fall; busy=1.
    - R/W=0: go to WR_BYTE with first_byte=1.
    - R/W=1: go to RD_BYTE, loading reg[ptr], and drive its MSB on the same fall that ends the ACK.
  - WR_BYTE: shift 8 bits in, then go to WR_ACK and ACK as above.
    - If first_byte: ptr = byte[AW-1:0]; upper bits are ignored; no wr_valid.
    - Otherwise: reg[ptr] = byte; wr_valid pulse with wr_reg=ptr, wr_data=byte; ptr = ptr+1 mod N_REGS.
    - Write and pulse occur on the clk after the 8th SCL rise.
  - RD_BYTE: drive 8 bits (drive low for 0, z for 1), updating on each SCL fall. Release SDA on the fall after bit 0. ptr = ptr+1 mod N_REGS when the byte is loaded. Then go to RD_ACK.
  - RD_ACK: sample the initiator ACK on the SCL rise.
    - 0: load reg[ptr] and continue RD_BYTE.
    - 1 (NACK): go to IGNORE with SDA released.
  - IGNORE: SDA released; wait for START or STOP.
- STOP in any state: go to IDLE, release SDA, busy=0, abandon any partial byte (no write, no pulse).
- START in any state (repeated start): go to ADDR, release SDA, busy=0, reset the bit counter.
- ptr persists across transactions, so a write-pointer, repeated-start, read sequence works.
- No clock stretching; the block never holds SCL.

## Timing
- Reset (rst=0): asynchronous.
  - sda released (z) immediately.
  - State IDLE; ptr=0; all registers=8'h00.
  - wr_valid=0, wr_reg=0, wr_data=0, busy=0.
- Detection latency: 3 clk from a bus edge to its internal event; SDA drive changes 3–4 clk after the SCL fall that triggers them.
- With clk ≥ 8× SCL, the change lands well before the next SCL rise. SDA hold after SCL fall is ≥ 3 clk.
- wr_valid is a single-clk pulse, never back-to-back within fewer than 8 SCL periods.
- busy rises on the clk after the 8th address bit matches.
- SDA transitions while scl=1 are START/STOP only when the block is not itself driving SDA. The block's own drive changes never coincide with scl=1 because it updates only after a fall.

## Test plan
- Write burst with DEV_ADDR=7'h50: START, 0xA0, 0x03, 0xA5, 0x3C, STOP → ACK on all four bytes; wr_valid pulses (3,A5) then (4,3C); busy returns to 0 after STOP.
- Pointer write then read: START, 0xA0, 0x03, Sr, 0xA1, read two bytes (initiator ACK then NACK), STOP → data A5 then 3C; SDA released after the NACK.
- Address mismatch: START, 0xA2, 0x00, 0x55, STOP → SDA never driven low; no wr_valid; busy stays 0.
- Pointer wrap: write ptr 0x0F, data 0x11, 0x22 → pulses (15,11) then (0,22); a readback from ptr 0x0F returns 11, 22.
- Aborted write: START, 0xA0, 0x05, then 4 data bits, then STOP → no wr_valid; reg[5] unchanged; state IDLE, accepting a new START.
- Reset mid-read: rst=0 while the block drives a 0 bit → sda goes z within the same clk; all outputs are 0; a following read of reg[3] returns 0x00.

Source files
------------

// File: rtl/i2c_target_regs.sv
// I2C target with an internal byte register file; oversamples SCL/SDA on clk,
// ACKs by pulling SDA low and reports every register written over the bus.
module i2c_target_regs #(
  parameter logic [6:0]  DEV_ADDR = 7'h50,
  parameter int unsigned N_REGS   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       scl,
  inout  wire                        sda,
  output logic                       wr_valid,
  output logic [$clog2(N_REGS)-1:0]  wr_reg,
  output logic [7:0]                 wr_data,
  output logic                       busy
);

  localparam int unsigned AW = $clog2(N_REGS);
  localparam int unsigned CW = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_IGNORE
  } state_t;

  state_t          state, state_nxt;
  logic            scl_s1, scl_s2, scl_h;
  logic            sda_s1, sda_s2, sda_h;
  logic            scl_rise, scl_fall, start_det, stop_det;
  logic            sda_oe, sda_oe_nxt;
  logic            busy_nxt;
  logic [7:0]      shreg, shreg_nxt;
  logic [CW-1:0]   bit_cnt, bit_cnt_nxt;
  logic [AW-1:0]   ptr, ptr_nxt;
  logic            first_byte, first_nxt;
  logic            rw, rw_nxt;
  logic            wr_valid_nxt;
  logic [AW-1:0]   wr_reg_nxt;
  logic [7:0]      wr_data_nxt;
  logic            reg_we;
  logic [7:0]      rx_byte, rd_byte;
  logic [7:0]      regs [N_REGS];

  // Open-drain pad: only ever pull low or release.
  assign sda = sda_oe ? 1'b0 : 1'bz;

  // Two-stage synchronizers plus one history stage; idle bus reads high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_h <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_h <= 1'b1;
    end else begin
      scl_s1 <= scl;    scl_s2 <= scl_s1; scl_h <= scl_s2;
      sda_s1 <= sda;    sda_s2 <= sda_s1; sda_h <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_h;
  assign scl_fall  = ~scl_s2 & scl_h;
  // Our own drive never changes while SCL is high, but gate on it anyway.
  assign start_det = scl_s2 & scl_h & sda_h & ~sda_s2 & ~sda_oe;
  assign stop_det  = scl_s2 & scl_h & ~sda_h & sda_s2 & ~sda_oe;

  assign rx_byte = {shreg[6:0], sda_s2};
  assign rd_byte = regs[ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      ptr        <= '0;
      first_byte <= 1'b0;
      rw         <= 1'b0;
      wr_valid   <= 1'b0;
      wr_reg     <= '0;
      wr_data    <= '0;
    end else begin
      state      <= state_nxt;
      sda_oe     <= sda_oe_nxt;
      busy       <= busy_nxt;
      shreg      <= shreg_nxt;
      bit_cnt    <= bit_cnt_nxt;
      ptr        <= ptr_nxt;
      first_byte <= first_nxt;
      rw         <= rw_nxt;
      wr_valid   <= wr_valid_nxt;
      wr_reg     <= wr_reg_nxt;
      wr_data    <= wr_data_nxt;
    end
  end

  // In the ACK states sda_oe doubles as the phase flag: low = waiting to start the ACK.
  always_comb begin
    state_nxt    = state;
    sda_oe_nxt   = sda_oe;
    busy_nxt     = busy;
    shreg_nxt    = shreg;
    bit_cnt_nxt  = bit_cnt;
    ptr_nxt      = ptr;
    first_nxt    = first_byte;
    rw_nxt       = rw;
    wr_valid_nxt = 1'b0;
    wr_reg_nxt   = wr_reg;
    wr_data_nxt  = wr_data;
    reg_we       = 1'b0;

    if (stop_det) begin
      state_nxt   = S_IDLE;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b0;
      bit_cnt_nxt = '0;
    end else if (start_det) begin
      state_nxt   = S_ADDR;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b0;
      bit_cnt_nxt = '0;
    end else begin
      case (state)
        S_IDLE, S_IGNORE: ;
        S_ADDR: begin
          if (scl_rise) begin
            shreg_nxt   = rx_byte;
            bit_cnt_nxt = bit_cnt + CW'(1);
            if (bit_cnt == CW'(7)) begin
              bit_cnt_nxt = '0;
              if (rx_byte[7:1] == DEV_ADDR) begin
                state_nxt = S_ADDR_ACK;
                busy_nxt  = 1'b1;
                rw_nxt    = rx_byte[0];
              end else begin
                state_nxt = S_IGNORE;
              end
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_nxt = 1'b1;
            end else if (rw) begin
              // Read: the fall that ends the ACK also presents the MSB.
              shreg_nxt   = {rd_byte[6:0], 1'b0};
              sda_oe_nxt  = ~rd_byte[7];
              bit_cnt_nxt = CW'(1);
              ptr_nxt     = ptr + AW'(1);
              state_nxt   = S_RD_BYTE;
            end else begin
              sda_oe_nxt  = 1'b0;
              first_nxt   = 1'b1;
              bit_cnt_nxt = '0;
              state_nxt   = S_WR_BYTE;
            end
          end
        end
        S_WR_BYTE: begin
          if (scl_rise) begin
            shreg_nxt   = rx_byte;
            bit_cnt_nxt = bit_cnt + CW'(1);
            if (bit_cnt == CW'(7)) begin
              bit_cnt_nxt = '0;
              state_nxt   = S_WR_ACK;
              if (first_byte) begin
                ptr_nxt   = rx_byte[AW-1:0];
                first_nxt = 1'b0;
              end else begin
                reg_we       = 1'b1;
                wr_valid_nxt = 1'b1;
                wr_reg_nxt   = ptr;
                wr_data_nxt  = rx_byte;
                ptr_nxt      = ptr + AW'(1);
              end
            end
          end
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_nxt = 1'b1;
            end else begin
              sda_oe_nxt  = 1'b0;
              bit_cnt_nxt = '0;
              state_nxt   = S_WR_BYTE;
            end
          end
        end
        S_RD_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt == CW'(8)) begin
              sda_oe_nxt = 1'b0;
              state_nxt  = S_RD_ACK;
            end else begin
              sda_oe_nxt  = ~shreg[7];
              shreg_nxt   = {shreg[6:0], 1'b0};
              bit_cnt_nxt = bit_cnt + CW'(1);
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s2) begin
              shreg_nxt   = rd_byte;
              ptr_nxt     = ptr + AW'(1);
              bit_cnt_nxt = '0;
              state_nxt   = S_RD_BYTE;
            end else begin
              state_nxt = S_IGNORE;
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Register file; written only on a completed data byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N_REGS; i++) regs[i] <= '0;
    end else if (reg_we) begin
      regs[ptr] <= rx_byte;
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C initiator on a pulled-up open-drain SDA.
module tb_i2c_target_regs;

  localparam int unsigned Q = 10;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       m_sda;  // 1 = initiator releases SDA
  wire        sda;
  logic       wr_valid;
  logic [3:0] wr_reg;
  logic [7:0] wr_data;
  logic       busy;

  pullup (sda);
  assign sda = m_sda ? 1'bz : 1'b0;

  i2c_target_regs #(.DEV_ADDR(7'h50), .N_REGS(16)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda),
    .wr_valid(wr_valid), .wr_reg(wr_reg), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [11:0] wr_q[$];
  logic [7:0]  rd_q[$];
  logic        watch_nd = 1'b0;
  int          nd_viol = 0;
  logic        wv_prev = 1'b0;

  typedef struct {
    logic [7:0] ptr;
    logic [7:0] d0, d1;
    logic [3:0] er0, er1;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
    end
  endtask

  // Write-event scoreboard and SDA-drive watcher.
  always @(negedge clk) begin
    if (rst && wr_valid) begin
      if (wv_prev) check("wr_valid_single", 32'(wv_prev), 32'(1'b0));
      if (wr_q.size() == 0) check("wr_unexpected", {20'h0, wr_reg, wr_data}, 32'hFFFFFFFF);
      else check("wr_event", {20'h0, wr_reg, wr_data}, {20'h0, wr_q.pop_front()});
    end
    wv_prev <= wr_valid;
    if (watch_nd && m_sda && sda === 1'b0) nd_viol++;
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bit_cell(input logic b, output logic s);
    wait_q(); m_sda = b;
    wait_q(); scl = 1'b1;
    wait_q(); s = sda;
    wait_q(); scl = 1'b0;
  endtask

  task automatic i2c_start();
    wait_q(); m_sda = 1'b1;
    wait_q(); scl = 1'b1;
    wait_q(); m_sda = 1'b0;
    wait_q(); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_q(); m_sda = 1'b0;
    wait_q(); scl = 1'b1;
    wait_q(); m_sda = 1'b1;
    wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cell(b[i], s);
    bit_cell(1'b1, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic s;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      bit_cell(1'b1, s);
      b = {b[6:0], s};
    end
    bit_cell(nack, s);
  endtask

  task automatic wr_txn(input logic [7:0] ptr, input logic [7:0] d0, input logic [7:0] d1);
    logic a;
    i2c_start();
    send_byte(8'hA0, a); check("wr_addr_ack", 32'(a), 32'(1'b0));
    check("busy_after_match", 32'(busy), 32'(1'b1));
    send_byte(ptr, a);   check("wr_ptr_ack", 32'(a), 32'(1'b0));
    send_byte(d0, a);    check("wr_d0_ack", 32'(a), 32'(1'b0));
    send_byte(d1, a);    check("wr_d1_ack", 32'(a), 32'(1'b0));
    i2c_stop();
    check("busy_after_stop", 32'(busy), 32'(1'b0));
    check("wr_events_pending", 32'(wr_q.size()), 32'd0);
  endtask

  // Sets the pointer, repeated START, reads n bytes; expected bytes come from rd_q.
  task automatic rd_txn(input logic [7:0] ptr, input int n);
    logic a;
    logic [7:0] b;
    i2c_start();
    send_byte(8'hA0, a); check("rd_addr_w_ack", 32'(a), 32'(1'b0));
    send_byte(ptr, a);   check("rd_ptr_ack", 32'(a), 32'(1'b0));
    i2c_start();
    send_byte(8'hA1, a); check("rd_addr_r_ack", 32'(a), 32'(1'b0));
    for (int k = 0; k < n; k++) begin
      recv_byte(k == n - 1, b);
      if (rd_q.size() == 0) check("rd_unexpected", 32'(b), 32'hFFFFFFFF);
      else check("rd_data", 32'(b), 32'(rd_q.pop_front()));
    end
    wait_q();
    check("sda_released_after_nack", 32'(sda), 32'(1'b1));
    i2c_stop();
  endtask

  initial begin
    logic a, s;
    rst = 1'b0; scl = 1'b1; m_sda = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_wr_reg", 32'(wr_reg), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sda", 32'(sda), 32'(1'b1));
    rst = 1'b1;
    repeat (5) @(negedge clk);

    vecs[0] = '{ptr: 8'h03, d0: 8'hA5, d1: 8'h3C, er0: 4'd3,  er1: 4'd4};
    vecs[1] = '{ptr: 8'h0F, d0: 8'h11, d1: 8'h22, er0: 4'd15, er1: 4'd0};
    vecs[2] = '{ptr: 8'h85, d0: 8'h77, d1: 8'h5A, er0: 4'd5,  er1: 4'd6};
    vecs[3] = '{ptr: 8'h0A, d0: 8'h00, d1: 8'hFF, er0: 4'd10, er1: 4'd11};

    foreach (vecs[v]) begin
      wr_q.push_back({vecs[v].er0, vecs[v].d0});
      wr_q.push_back({vecs[v].er1, vecs[v].d1});
      wr_txn(vecs[v].ptr, vecs[v].d0, vecs[v].d1);
      rd_q.push_back(vecs[v].d0);
      rd_q.push_back(vecs[v].d1);
      rd_txn(vecs[v].ptr, 2);
    end

    // Foreign address: never ACKs, never drives SDA, no writes.
    watch_nd = 1'b1;
    i2c_start();
    send_byte(8'hA2, a); check("mismatch_addr_nack", 32'(a), 32'(1'b1));
    check("mismatch_busy", 32'(busy), 32'(1'b0));
    send_byte(8'h00, a); check("mismatch_b1_nack", 32'(a), 32'(1'b1));
    send_byte(8'h55, a); check("mismatch_b2_nack", 32'(a), 32'(1'b1));
    i2c_stop();
    watch_nd = 1'b0;
    check("mismatch_sda_driven", 32'(nd_viol), 32'd0);
    check("mismatch_busy_end", 32'(busy), 32'(1'b0));

    // Write aborted by STOP after four data bits leaves reg[5] intact.
    i2c_start();
    send_byte(8'hA0, a); check("abort_addr_ack", 32'(a), 32'(1'b0));
    send_byte(8'h05, a); check("abort_ptr_ack", 32'(a), 32'(1'b0));
    bit_cell(1'b1, s); bit_cell(1'b0, s); bit_cell(1'b1, s); bit_cell(1'b0, s);
    i2c_stop();
    check("abort_busy", 32'(busy), 32'(1'b0));
    rd_q.push_back(8'h77);
    rd_txn(8'h05, 1);
    check("abort_no_write", 32'(wr_q.size()), 32'd0);

    // Reset while the target drives a 0 bit of reg[3]=A5.
    i2c_start();
    send_byte(8'hA0, a); check("rstrd_addr_ack", 32'(a), 32'(1'b0));
    send_byte(8'h03, a); check("rstrd_ptr_ack", 32'(a), 32'(1'b0));
    i2c_start();
    send_byte(8'hA1, a); check("rstrd_addr_r_ack", 32'(a), 32'(1'b0));
    bit_cell(1'b1, s);   check("rstrd_bit7", 32'(s), 32'(1'b1));
    wait_q();
    check("rstrd_bit6_driven", 32'(sda), 32'(1'b0));
    #2 rst = 1'b0;
    #1 check("rstrd_sda_released", 32'(sda), 32'(1'b1));
    check("rstrd_wr_valid", 32'(wr_valid), 32'd0);
    check("rstrd_wr_reg", 32'(wr_reg), 32'd0);
    check("rstrd_wr_data", 32'(wr_data), 32'd0);
    check("rstrd_busy", 32'(busy), 32'd0);
    scl = 1'b1; m_sda = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rd_q.push_back(8'h00);
    rd_txn(8'h03, 1);

    repeat (20) @(negedge clk);
    check("final_wr_pending", 32'(wr_q.size()), 32'd0);
    check("final_rd_pending", 32'(rd_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
